// File: rtl/twiddle_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// twiddle_gen : multi-lane FFT twiddle stream built from a quarter-wave table
// Revision    : 1.0
// ----------------------------------------------------------------------------
module twiddle_gen #(
  parameter  int WIDTH = 9,
  parameter  int N     = 64,
  parameter  int LANES = 16,
  localparam int BEATS = N / LANES,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   inv,
  input  logic                   en,
  output logic                   busy,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [BW-1:0]          out_beat,
  output logic [LANES*WIDTH-1:0] tw_re,
  output logic [LANES*WIDTH-1:0] tw_im
);

  localparam int LOG2N = $clog2(N);
  localparam int LOG2R = LOG2N / 2;
  localparam int LOG2L = $clog2(LANES);
  localparam int IW    = LOG2N - 1;
  localparam int QTR   = N / 4;
  localparam int S     = 1 << (WIDTH - 2);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [IW-1:0] QTR_IDX   = IW'(QTR);

  // Angles stay within [0, pi/2], so a short Taylor series is exact to well
  // below one LSB; int'() of a real rounds half away from zero.
  function automatic logic signed [WIDTH-1:0] cos_entry(input int q);
    real x, term, sum;
    int  v;
    x    = 2.0 * 3.14159265358979323846 * real'(q) / real'(N);
    term = 1.0;
    sum  = 1.0;
    for (int t = 1; t < 14; t++) begin
      term = -term * x * x / real'((2 * t - 1) * (2 * t));
      sum  = sum + term;
    end
    v = int'(sum * real'(S));
    return v[WIDTH-1:0];
  endfunction

  logic signed [WIDTH-1:0] cos_tab [QTR+1];
  for (genvar q = 0; q <= QTR; q++) begin : g_tab
    assign cos_tab[q] = cos_entry(q);
  end

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          inv_q, inv_d;
  logic          issue;
  logic [BW-1:0] issue_beat;
  logic          issue_inv;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inv_d      = inv_q;
    issue      = 1'b0;
    issue_beat = cnt_q;
    issue_inv  = inv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          issue      = 1'b1;
          issue_beat = '0;
          issue_inv  = inv;
          inv_d      = inv;
          if (BEATS > 1) begin
            state_d = RUN;
            cnt_d   = BW'(1);
          end
        end
      end
      RUN: begin
        issue = 1'b1;
        cnt_d = cnt_q + BW'(1);
        if (cnt_q == LAST_BEAT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic          s1_valid_q, s1_last_q, s2_valid_q, s2_last_q;
  logic [BW-1:0] s1_beat_q, s2_beat_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inv_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_beat_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_beat_q  <= '0;
    end else if (en) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inv_q      <= inv_d;
      s1_valid_q <= issue;
      s1_last_q  <= issue && (issue_beat == LAST_BEAT);
      s1_beat_q  <= issue_beat;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_beat_q  <= s1_beat_q;
    end
  end

  assign busy      = (state_q == RUN);
  assign out_valid = s2_valid_q;
  assign out_last  = s2_last_q;
  assign out_beat  = s2_beat_q;

  logic [LOG2N-1:0] base_idx;
  assign base_idx = LOG2N'(issue_beat) << LOG2L;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LOG2N-1:0]        idx, e;
    logic [LOG2R-1:0]        row, col, krev;
    logic [IW-1:0]           m_idx, c_idx;
    logic [IW-1:0]           re_idx_d, re_idx_q, im_idx_d, im_idx_q;
    logic                    re_neg_d, re_neg_q, im_neg_d, im_neg_q;
    logic signed [WIDTH-1:0] re_q, im_q;

    // Odd quadrants swap the cos/sin table roles; quadrant bits set the signs.
    always_comb begin
      idx  = base_idx + LOG2N'(l);
      row  = idx[LOG2N-1 -: LOG2R];
      col  = idx[LOG2R-1:0];
      krev = '0;
      for (int j = 0; j < LOG2R; j++) krev[j] = row[LOG2R-1-j];
      e        = LOG2N'(krev) * LOG2N'(col);
      m_idx    = IW'(e[LOG2N-3:0]);
      c_idx    = QTR_IDX - m_idx;
      re_idx_d = e[LOG2N-2] ? c_idx : m_idx;
      im_idx_d = e[LOG2N-2] ? m_idx : c_idx;
      re_neg_d = e[LOG2N-1] ^ e[LOG2N-2];
      im_neg_d = ~e[LOG2N-1] ^ issue_inv;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        re_idx_q <= '0;
        im_idx_q <= '0;
        re_neg_q <= 1'b0;
        im_neg_q <= 1'b0;
        re_q     <= '0;
        im_q     <= '0;
      end else if (en) begin
        re_idx_q <= re_idx_d;
        im_idx_q <= im_idx_d;
        re_neg_q <= re_neg_d;
        im_neg_q <= im_neg_d;
        re_q     <= re_neg_q ? -cos_tab[re_idx_q] : cos_tab[re_idx_q];
        im_q     <= im_neg_q ? -cos_tab[im_idx_q] : cos_tab[im_idx_q];
      end
    end

    assign tw_re[l*WIDTH +: WIDTH] = re_q;
    assign tw_im[l*WIDTH +: WIDTH] = im_q;
  end

endmodule
`default_nettype wire
